// File: rtl/pet_video_gen_if.sv
// pet_video_gen_if: screen RAM / character ROM fetch bus between the video generator and memory.
interface pet_video_gen_if #(parameter int ADDR_W = 11);
  logic [ADDR_W-1:0] video_addr;
  logic [7:0]        video_data;
  logic [10:0]       charaddr;
  logic [7:0]        chardata;
  logic              video_gfx;
  modport master (output video_addr, charaddr, input video_data, chardata, video_gfx);
  modport slave  (input video_addr, charaddr, output video_data, chardata, video_gfx);
endinterface

// File: rtl/pet_video_gen.sv
// pet_video_gen: parametrised PET text-mode video generator with per-frame scroll base and sync/blank timing.
module pet_video_gen #(
  parameter int COLS       = 40,
  parameter int ROWS       = 25,
  parameter int CHAR_H     = 8,
  parameter int H_TOTAL    = 64,
  parameter int V_TOTAL    = 260,
  parameter int HBLANK_ON  = 46,
  parameter int HSYNC_ON   = 50,
  parameter int HSYNC_OFF  = 54,
  parameter int HBLANK_OFF = 58,
  parameter int VBLANK_ON  = 220,
  parameter int VSYNC_ON   = 226,
  parameter int VSYNC_OFF  = 234,
  parameter int VBLANK_OFF = 240,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [ADDR_W-1:0] start_addr,
  pet_video_gen_if.master   mem,
  input  logic              video_blank,
  output logic              pix,
  output logic              HSync,
  output logic              VSync,
  output logic              HBlank,
  output logic              VBlank,
  output logic              video_on
);
  localparam int HPIX = H_TOTAL * 8;
  localparam int HW   = $clog2(HPIX);
  localparam int VW   = $clog2(V_TOTAL);
  localparam int VIS  = ROWS * CHAR_H;
  localparam logic [VW-1:0] CH = VW'(CHAR_H);
  logic [HW-1:0]     hc_q, hc_d;
  logic [VW-1:0]     vc_q, vc_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, fetch_addr;
  logic [7:0]        sr_q, sr_d;
  logic              inv_q, inv_d;
  logic              hs_q, hs_d, hb_q, hb_d, vs_q, vs_d, vb_q, vb_d, von_q, von_d;
  logic [HW-4:0]     col;
  logic [VW-1:0]     row, line;
  logic [ADDR_W:0]   row_off;
  logic              in_win, load, last_h, last_v, h0, von_hit;
  function automatic logic upd(input logic q, input logic on, input logic off);
    return on ? 1'b1 : off ? 1'b0 : q;
  endfunction
  always_comb begin
    col        = hc_q[HW-1:3];
    row        = vc_q / CH;
    line       = vc_q % CH;
    in_win     = (int'(col) < COLS) && (int'(vc_q) < VIS);
    load       = in_win && (int'(line) < 8);
    row_off    = (ADDR_W+1)'(row) * (ADDR_W+1)'(COLS);
    fetch_addr = base_q + row_off[ADDR_W-1:0] + ADDR_W'(col);
    addr_d     = in_win ? fetch_addr : addr_q;
    last_h     = hc_q == HW'(HPIX - 1);
    last_v     = vc_q == VW'(V_TOTAL - 1);
    h0         = hc_q == '0;
    von_hit    = hc_q == HW'(COLS * 8 + 15);
    hc_d       = !ce_pix ? hc_q : last_h ? '0 : hc_q + HW'(1);
    vc_d       = !(ce_pix && last_h) ? vc_q : last_v ? '0 : vc_q + VW'(1);
    base_d     = ce_pix && last_h && last_v ? start_addr : base_q;
    // Lines 8/9 of a 10-line cell still fetch but load a blank pattern.
    {inv_d, sr_d} = !ce_pix ? {inv_q, sr_q}
                  : hc_q[2:0] == 3'd7 ? (load ? {mem.video_data[7], mem.chardata} : 9'b0)
                  : {inv_q, sr_q[6:0], 1'b0};
    hb_d  = ce_pix ? upd(hb_q, hc_q == HW'(HBLANK_ON*8-1), hc_q == HW'(HBLANK_OFF*8-1)) : hb_q;
    hs_d  = ce_pix ? upd(hs_q, hc_q == HW'(HSYNC_ON*8-1), hc_q == HW'(HSYNC_OFF*8-1)) : hs_q;
    vb_d  = ce_pix ? upd(vb_q, h0 && vc_q == VW'(VBLANK_ON), h0 && vc_q == VW'(VBLANK_OFF)) : vb_q;
    vs_d  = ce_pix ? upd(vs_q, h0 && vc_q == VW'(VSYNC_ON), h0 && vc_q == VW'(VSYNC_OFF)) : vs_q;
    von_d = ce_pix ? upd(von_q, von_hit && last_v, von_hit && vc_q == VW'(VIS - 1)) : von_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      hc_q   <= '0;
      vc_q   <= '0;
      base_q <= start_addr;
      addr_q <= '0;
      sr_q   <= '0;
      inv_q  <= 1'b0;
      hs_q   <= 1'b0;
      hb_q   <= 1'b0;
      vs_q   <= 1'b0;
      vb_q   <= 1'b0;
      von_q  <= 1'b1;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      base_q <= base_d;
      addr_q <= addr_d;
      sr_q   <= sr_d;
      inv_q  <= inv_d;
      hs_q   <= hs_d;
      hb_q   <= hb_d;
      vs_q   <= vs_d;
      vb_q   <= vb_d;
      von_q  <= von_d;
    end
  assign mem.video_addr = addr_d;
  assign mem.charaddr   = {mem.video_gfx, mem.video_data[6:0], line[2:0]};
  assign pix      = (sr_q[7] ^ inv_q) & ~video_blank;
  assign HSync    = hs_q;
  assign HBlank   = hb_q;
  assign VSync    = vs_q;
  assign VBlank   = vb_q;
  assign video_on = von_q;
endmodule

// File: tb/tb_pet_video_gen.sv
// tb_pet_video_gen: directed checks of a 40-col (short frame) and an 80-col/10-line generator.
module tb_pet_video_gen;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b1;
  logic [10:0] sa1 = 11'h000, sa2 = 11'h000;
  logic blank1 = 1'b0, blank2 = 1'b0;
  logic pix1, hs1, vs1, hb1, vb1, von1;
  logic pix2, hs2, vs2, hb2, vb2, von2;
  logic [7:0] mem1 [2048];
  logic [7:0] mem2 [2048];
  logic [7:0] rom  [2048];
  int pos = 0, checks = 0, errors = 0;
  logic [7:0] e1, e2;
  pet_video_gen_if #(.ADDR_W(11)) m1 ();
  pet_video_gen_if #(.ADDR_W(11)) m2 ();
  assign m1.video_data = mem1[m1.video_addr];
  assign m1.chardata   = rom[m1.charaddr];
  assign m1.video_gfx  = 1'b0;
  assign m2.video_data = mem2[m2.video_addr];
  assign m2.chardata   = rom[m2.charaddr];
  assign m2.video_gfx  = 1'b0;
  pet_video_gen #(.COLS(40), .ROWS(3), .CHAR_H(8), .H_TOTAL(64), .V_TOTAL(40),
    .VBLANK_ON(30), .VSYNC_ON(32), .VSYNC_OFF(35), .VBLANK_OFF(37), .ADDR_W(11)) d1 (
    .clk(clk), .reset(reset), .ce_pix(ce), .start_addr(sa1), .mem(m1), .video_blank(blank1),
    .pix(pix1), .HSync(hs1), .VSync(vs1), .HBlank(hb1), .VBlank(vb1), .video_on(von1));
  pet_video_gen #(.COLS(80), .ROWS(2), .CHAR_H(10), .H_TOTAL(128), .V_TOTAL(24),
    .VBLANK_ON(20), .VSYNC_ON(21), .VSYNC_OFF(22), .VBLANK_OFF(23), .ADDR_W(11)) d2 (
    .clk(clk), .reset(reset), .ce_pix(ce), .start_addr(sa2), .mem(m2), .video_blank(blank2),
    .pix(pix2), .HSync(hs2), .VSync(vs2), .HBlank(hb2), .VBlank(vb2), .video_on(von2));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (reset) pos <= 0;
    else if (ce) pos <= pos + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic at(input int p);
    int n = 0;
    while (pos < p) begin
      @(negedge clk);
      n++;
      if (n > 100000) begin
        $display("FAIL timeout waiting for pos %0d observed %0d", p, pos);
        $fatal(1);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
      rom[i]  = 8'h00;
    end
    mem1[0] = 8'h01;
    mem1[1] = 8'h81;
    mem1[3] = 8'h02;
    mem2[0] = 8'h81;
    rom[8]  = 8'hAA;
    for (int i = 16; i < 24; i++) rom[i] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_pix", pix1, 0);
    chk("rst_hsync", hs1, 0);
    chk("rst_vsync", vs1, 0);
    chk("rst_hblank", hb1, 0);
    chk("rst_vblank", vb1, 0);
    chk("rst_video_on", von1, 1);
    chk("rst_video_on_80", von2, 1);
    reset = 1'b0;
    at(0);
    chk("addr_origin", m1.video_addr, 0);
    chk("addr_origin_80", m2.video_addr, 0);
    at(3);
    chk("pix_before_first_load", pix1, 0);
    e1 = 8'hAA;
    e2 = 8'h55;
    for (int i = 0; i < 8; i++) begin
      at(8 + i);
      chk("pix_col0", pix1, e1[7-i]);
      chk("pix_col0_inv_80", pix2, e2[7-i]);
    end
    for (int i = 0; i < 8; i++) begin
      at(16 + i);
      chk("pix_col1_inv", pix1, e2[7-i]);
    end
    at(26);
    chk("pix_col2_inv_cleared", pix1, 0);
    at(32);
    chk("pix_ff_unblanked", pix1, 1);
    blank1 = 1'b1;
    #1 chk("pix_blank_same_cycle", pix1, 0);
    at(33);
    chk("pix_blank_held", pix1, 0);
    at(34);
    blank1 = 1'b0;
    #1 chk("pix_unblank_same_cycle", pix1, 1);
    at(43);
    chk("addr_col5", m1.video_addr, 5);
    at(367);
    chk("hblank_before_rise", hb1, 0);
    at(368);
    chk("hblank_rise", hb1, 1);
    at(398);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    chk("hsync_held_no_ce", hs1, 0);
    ce = 1'b1;
    at(399);
    chk("hsync_before_rise", hs1, 0);
    at(400);
    chk("hsync_rise", hs1, 1);
    chk("addr_hold_right_margin", m1.video_addr, 39);
    at(431);
    chk("hsync_before_fall", hs1, 1);
    at(432);
    chk("hsync_fall", hs1, 0);
    at(463);
    chk("hblank_before_fall", hb1, 1);
    at(464);
    chk("hblank_fall", hb1, 0);
    at(639);
    chk("addr_last_col_80", m2.video_addr, 79);
    at(640);
    chk("addr_no_fetch_640_80", m2.video_addr, 79);
    at(911);
    chk("hsync_line1_before", hs1, 0);
    at(912);
    chk("hsync_line1_period", hs1, 1);
    at(1000);
    chk("addr_no_fetch_1000_80", m2.video_addr, 79);
    at(1033);
    chk("pix_line1_inv_80", pix2, 1);
    at(4096);
    chk("addr_row1", m1.video_addr, 40);
    at(5120);
    sa1 = 11'h7F0;
    at(8192);
    chk("addr_row2_midframe_start_change", m1.video_addr, 80);
    for (int i = 0; i < 8; i++) begin
      at(8200 + i);
      chk("pix_line8_blank_80", pix2, 0);
    end
    at(10240);
    chk("addr_row1_80", m2.video_addr, 80);
    at(12111);
    chk("video_on_before_fall", von1, 1);
    at(12112);
    chk("video_on_fall", von1, 0);
    at(12288);
    chk("addr_hold_below_text", m1.video_addr, 119);
    at(15359);
    chk("vblank_before_rise", vb1, 0);
    at(15361);
    chk("vblank_rise", vb1, 1);
    at(16384);
    chk("vsync_line32_hc0", vs1, 0);
    at(16385);
    chk("vsync_rise", vs1, 1);
    at(17296);
    chk("hsync_in_vsync", hs1, 1);
    at(17920);
    chk("vsync_line35_hc0", vs1, 1);
    at(17921);
    chk("vsync_fall", vs1, 0);
    at(18945);
    chk("vblank_fall", vb1, 0);
    at(20111);
    chk("video_on_before_fall_80", von2, 1);
    at(20112);
    chk("video_on_fall_80", von2, 0);
    at(20303);
    chk("video_on_before_rise", von1, 0);
    at(20304);
    chk("video_on_rise", von1, 1);
    at(20480);
    chk("addr_frame1_base", m1.video_addr, 11'h7F0);
    at(20600);
    chk("addr_frame1_col15", m1.video_addr, 11'h7FF);
    at(20608);
    chk("addr_frame1_col16_wrap", m1.video_addr, 11'h000);
    at(24576);
    chk("addr_frame1_row1_wrap", m1.video_addr, 11'h018);
    at(36864);
    chk("vsync_frame1_before", vs1, 0);
    at(36865);
    chk("vsync_frame1_period", vs1, 1);
    at(58256);
    chk("pre_rst_hsync", hs1, 1);
    chk("pre_rst_vsync", vs1, 1);
    chk("pre_rst_video_on", von1, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_hsync", hs1, 0);
    chk("mid_rst_vsync", vs1, 0);
    chk("mid_rst_hblank", hb1, 0);
    chk("mid_rst_vblank", vb1, 0);
    chk("mid_rst_video_on", von1, 1);
    chk("mid_rst_origin_addr", m1.video_addr, 11'h7F0);
    reset = 1'b0;
    at(8);
    chk("post_rst_col1_addr", m1.video_addr, 11'h7F1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pet_video_gen.md
Name: pet_video_gen

Overview:
- Parametrised PET text-mode video generator; successor to the fixed 40x25 generator.
- Same cell (8 pixels x CHAR_H lines); column count, timing and screen memory size are parameters, so one block serves 40-col (2001/4032) and 80-col (8032) machines.
- Adds a per-frame latched start address (hardware scroll, wraps in screen RAM) and a parametrised sync/blank placement.
- Sits between screen RAM / character ROM and the video scaler; drives the video_on (60 Hz IRQ / snow-avoidance) line to the VIA.

Parameters:
COLS, 40, visible text columns (40 or 80)
ROWS, 25, visible text rows
CHAR_H, 8, scan lines per text row (8 or 10)
H_TOTAL, 64, character slots per scan line (128 for 80-col)
V_TOTAL, 260, scan lines per frame
HBLANK_ON, 46, char slot where HBlank rises
HSYNC_ON, 50, char slot where HSync rises
HSYNC_OFF, 54, char slot where HSync falls
HBLANK_OFF, 58, char slot where HBlank falls
VBLANK_ON, 220, line where VBlank rises
VSYNC_ON, 226, line where VSync rises
VSYNC_OFF, 234, line where VSync falls
VBLANK_OFF, 240, line where VBlank falls
ADDR_W, 11, screen RAM address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ce_pix  in  1  pixel clock enable (8 MHz for 40-col, 16 MHz for 80-col)
start_addr  in  ADDR_W  screen RAM address of row 0, column 0
video_addr  out  ADDR_W  screen RAM address
video_data  in  8  screen code; bit 7 = inverse
charaddr  out  11  {video_gfx, video_data[6:0], line-in-row[2:0]}
chardata  in  8  character ROM row, MSB leftmost
video_gfx  in  1  character set select
video_blank  in  1  forces pix low
pix  out  1  pixel
HSync, VSync, HBlank, VBlank  out  1 each  sync/blank, active-high
video_on  out  1  high outside the text-fetch window

Behaviour:
- Reset (clk edge with reset=1): hc=0, vc=0, pix=0, HSync=0, VSync=0, HBlank=0, VBlank=0, video_on=1, shift register and inverse flag cleared, frame base = start_addr. Reset overrides ce_pix. Mid-frame reset restarts at origin on the next clk.
- Counters advance only on ce_pix:
  - hc counts pixels 0..H_TOTAL*8-1, then wraps.
  - vc increments at hc wrap: 0..V_TOTAL-1, then wraps.
  - Origin (hc=0, vc=0) is the first pixel slot of text column 0, text line 0.
- Fetch window: col=hc[..:3] < COLS and vc < ROWS*CHAR_H.
  - row = vc / CHAR_H; line = vc mod CHAR_H.
  - video_addr = base + row*COLS + col, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
  - Outside the window, video_addr holds the last computed value.
- Start-address latching: base latches start_addr on the ce_pix where vc=V_TOTAL-1 and hc=H_TOTAL*8-1. Changes to start_addr mid-frame have no effect until the next frame.
- Memory contract:
  - video_addr for column c is stable across pixel slots 8c..8c+7.
  - video_data, and chardata for the resulting charaddr, must be valid by the ce_pix of slot 8c+7.
- Shift register:
  - On the ce_pix with hc[2:0]=7 it loads {inv, sr} = {video_data[7], chardata} if that column was inside the fetch window, else 9'b0.
  - On every other ce_pix it shifts left, zero fill.
  - The pixels of column c appear in slots 8(c+1)..8(c+1)+7; latency is 8 pixels.
- pix = (sr[7] ^ inv) & ~video_blank. video_blank acts combinationally on the same cycle.
- CHAR_H=10: lines 8 and 9 of each row fetch with charaddr line bits = line[2:0]; their output is forced blank (load 9'b0). There is no inverse bar in these lines.
- Sync/blank outputs update on ce_pix:
  - Horizontal edges at hc = X*8-1 for each parameter X.
  - Vertical edges at hc=0 of the named line.
  - The same register toggle rules hold in every line.
- video_on:
  - Falls at vc=ROWS*CHAR_H-1, hc=COLS*8+15 (last pixel shifted out).
  - Rises at vc=V_TOTAL-1, same hc.
- Width rules: row*COLS is computed at ADDR_W+1 bits, then truncated. All counters are sized by $clog2 of their totals.

Test Plan:
- Reset, then run 2 frames with default parameters: HSync period 512 ce_pix, VSync period 133120 ce_pix; VSync high for lines 226..233; video_on low for lines 199..259 (edge at hc=335).
- RAM model returns code 0x01 at address 0, chardata 0xAA: pix sequence 1,0,1,0,1,0,1,0 in slots 8..15 of line 0. With code 0x81, pix is inverted: 0,1,0,1,...
- start_addr=0x7F0 with ADDR_W=11: row 1, col 0 fetches 0x018 (wrap). Changing start_addr at line 100 leaves the current frame's addresses unchanged.
- COLS=80, H_TOTAL=128: the last fetch in line 0 is column 79 at address 79, with no fetch at hc>=640. video_on falls at hc=655.
- video_blank=1 with all-0xFF chardata gives pix=0. Deasserting video_blank restores pix=1 in the same cycle.
- Reset asserted at vc=120, hc=200: the next clk gives hc=0, vc=0, video_on=1, and all sync/blank outputs 0.
